uart: RTL and testbench



---
 rtl/uart.sv | 239 +++++++++++++++++++++++
 tb/tb_uart.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart: full-duplex 8N1 transceiver, DIV = CLOCKFRQ/BAUDRATE clocks per bit (DIV >= 4).
// Define UART_RX_SYNC_EN to put a 2-flop synchroniser (reset high) in front of the receiver.
//
// TX state  | meaning
// TX_IDLE   | line high, tx_free=1, waiting for transmit
// TX_START  | driving start bit (0)
// TX_DATA   | driving data bit tx_bit, LSB first
// TX_STOP   | driving stop bit (1)
//
// RX state     | meaning
// RX_IDLE      | waiting for a low level on the conditioned line
// RX_START     | counting to mid start bit; high sample there is a false start
// RX_DATA      | sampling data bit rx_bit at mid-bit
// RX_STOP      | sampling stop bit at mid-bit
// RX_WAIT_IDLE | framing error seen; waiting for the line to return high
module uart #(
  parameter int CLOCKFRQ = 1_000_000,
  parameter int BAUDRATE = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic       tx_free,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int DIV = CLOCKFRQ / BAUDRATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic rx_in;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx};
  end

  assign rx_in = rx_sync[1];
`else
  assign rx_in = rx;
`endif

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_shift, tx_shift_nx;
  logic          tx_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      tx       <= tx_nx;
    end
  end

  // tx is registered and set from the next state, so the line changes on the accepting edge.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_nx       = tx;
    case (tx_state)
      TX_IDLE: begin
        tx_nx = 1'b1;
        if (transmit) begin
          tx_state_nx = TX_START;
          tx_cnt_nx   = BIT_LAST;
          tx_shift_nx = tx_byte;
          tx_nx       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - CW'(1);
        end else begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = BIT_LAST;
          tx_bit_nx   = '0;
          tx_nx       = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - CW'(1);
        end else begin
          tx_cnt_nx = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_state_nx = TX_STOP;
            tx_nx       = 1'b1;
          end else begin
            tx_bit_nx   = tx_bit + 3'd1;
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_nx       = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        tx_nx = 1'b1;
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - CW'(1);
        end else begin
          tx_state_nx = TX_IDLE;
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_nx       = 1'b1;
      end
    endcase
  end

  assign is_transmitting = (tx_state != TX_IDLE);
  assign tx_free         = ~is_transmitting;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic [7:0]    rx_byte_nx;
  logic          received_nx;
  logic          recv_error_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      received   <= 1'b0;
      recv_error <= 1'b0;
    end else begin
      rx_state   <= rx_state_nx;
      rx_cnt     <= rx_cnt_nx;
      rx_bit     <= rx_bit_nx;
      rx_shift   <= rx_shift_nx;
      rx_byte    <= rx_byte_nx;
      received   <= received_nx;
      recv_error <= recv_error_nx;
    end
  end

  // The half-bit load on entry to RX_START puts every later sample at mid-bit.
  always_comb begin
    rx_state_nx   = rx_state;
    rx_cnt_nx     = rx_cnt;
    rx_bit_nx     = rx_bit;
    rx_shift_nx   = rx_shift;
    rx_byte_nx    = rx_byte;
    received_nx   = 1'b0;
    recv_error_nx = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_in) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - CW'(1);
        end else if (rx_in) begin
          rx_state_nx = RX_IDLE;
        end else begin
          rx_state_nx = RX_DATA;
          rx_cnt_nx   = BIT_LAST;
          rx_bit_nx   = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - CW'(1);
        end else begin
          rx_shift_nx = {rx_in, rx_shift[7:1]};
          rx_cnt_nx   = BIT_LAST;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - CW'(1);
        end else if (rx_in) begin
          rx_state_nx = RX_IDLE;
          rx_byte_nx  = rx_shift;
          received_nx = 1'b1;
        end else begin
          rx_state_nx   = RX_WAIT_IDLE;
          recv_error_nx = 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_in) rx_state_nx = RX_IDLE;
      end
      default: begin
        rx_state_nx = RX_IDLE;
      end
    endcase
  end

  assign is_receiving = (rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart.sv
// tb_uart: scoreboard bench for uart; a line-level frame model checks tx, a queue of
// expected receive events checks received/recv_error/rx_byte.
`timescale 1ns/1ps
module tb_uart;
  localparam int CLOCKFRQ = 1_000_000;
  localparam int BAUDRATE = 250_000;
  localparam int DIV      = CLOCKFRQ / BAUDRATE;
  localparam int DLY      = CLOCKFRQ / 1000 * 15;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx;
  logic       tx;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       received;
  logic       tx_free;
  logic [7:0] rx_byte;
  logic       is_receiving;
  logic       is_transmitting;
  logic       recv_error;

  logic rx_drv  = 1'b1;
  logic rx_dly  = 1'b1;
  logic loop_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } rx_ev_t;

  rx_ev_t     rxq[$];
  logic [7:0] txq[$];
  logic [7:0] last_good = 8'h00;

  assign rx = loop_en ? rx_dly : rx_drv;

  uart #(.CLOCKFRQ(CLOCKFRQ), .BAUDRATE(BAUDRATE)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .tx              (tx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .received        (received),
    .tx_free         (tx_free),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .recv_error      (recv_error)
  );

  always #500 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // 15 ms transport delay from tx to rx for the loopback test
  bit ring [DLY];
  initial begin : line_delay
    int p;
    p = 0;
    for (int i = 0; i < DLY; i++) ring[i] = 1'b1;
    forever begin
      @(negedge clk);
      rx_dly  = ring[p];
      ring[p] = loop_en ? tx : 1'b1;
      p = (p == DLY - 1) ? 0 : p + 1;
    end
  end

  initial begin : tx_mon
    logic [9:0] frame;
    logic [7:0] want;
    logic       seen;
    logic       free_seen;
    bit         abort;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b1 && tx === 1'b0) begin
        if (txq.size() == 0) begin
          fail("tx_unexpected_frame", "got a start bit, required an idle line");
          want = 8'h00;
        end else begin
          want = txq.pop_front();
        end
        frame     = {1'b1, want, 1'b0};
        abort     = 1'b0;
        free_seen = 1'b0;
        for (int k = 0; k < 10 && !abort; k++) begin
          seen = frame[k];
          for (int c = 0; c < DIV && !abort; c++) begin
            if (k != 0 || c != 0) begin
              @(posedge clk); #1;
            end
            if (rst !== 1'b1) begin
              abort = 1'b1;
            end else begin
              if (tx !== frame[k]) seen = tx;
              if (tx_free !== 1'b0) free_seen = 1'b1;
            end
          end
          if (!abort) chk($sformatf("tx_byte_%02h_bit%0d", want, k), 32'(seen), 32'(frame[k]));
        end
        if (!abort) begin
          chk("tx_free_low_whole_frame", 32'(free_seen), 32'd0);
          @(posedge clk); #1;
          if (rst === 1'b1) chk("tx_free_after_frame", 32'(tx_free), 32'd1);
        end
      end
    end
  end

  initial begin : rx_mon
    rx_ev_t ev;
    forever begin
      @(posedge clk); #1;
      if (received === 1'b1 || recv_error === 1'b1) begin
        if (rxq.size() == 0) begin
          fail("rx_unexpected_event",
               $sformatf("got received=%0b recv_error=%0b, required none", received, recv_error));
        end else begin
          ev = rxq.pop_front();
          chk("rx_event_kind", 32'({received, recv_error}), ev.err ? 32'd1 : 32'd2);
          if (!ev.err) begin
            chk("rx_byte", 32'(rx_byte), 32'(ev.data));
            last_good = ev.data;
          end else begin
            chk("rx_byte_kept_on_error", 32'(rx_byte), 32'(last_good));
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_tx(input logic [7:0] b, input bit loop);
    int g;
    rx_ev_t ev;
    g = 0;
    while (tx_free !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail("tx_free_timeout", "got tx_free=0 for 200 cycles, required 1");
    transmit = 1'b1;
    tx_byte  = b;
    txq.push_back(b);
    if (loop) begin
      ev.err  = 1'b0;
      ev.data = b;
      rxq.push_back(ev);
    end
    @(negedge clk);
    transmit = 1'b0;
    tx_byte  = 8'($urandom);
  endtask

  task automatic wait_tx_idle();
    int g;
    g = 0;
    while (tx_free !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("tx_returns_idle", 32'(tx_free), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rxq(input int limit);
    int g;
    g = 0;
    while (rxq.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    chk("rx_events_drained", 32'(rxq.size()), 32'd0);
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic push_rx(input bit err, input logic [7:0] b);
    rx_ev_t ev;
    ev.err  = err;
    ev.data = b;
    rxq.push_back(ev);
  endtask

  // Called at a negedge; stop bit lasts stop_len (good) or DIV+low_hold (bad) cycles.
  task automatic drive_rx_frame(input logic [7:0] b, input bit stop_ok,
                                input int stop_len, input int low_hold);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int k = 0; k < 9; k++) begin
      rx_drv = f[k];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = stop_ok;
    repeat (stop_ok ? stop_len : DIV + low_hold) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin : stim
    rst    = 1'b0;
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_tx_free", 32'(tx_free), 32'd1);
    chk("reset_received", 32'(received), 32'd0);
    chk("reset_rx_byte", 32'(rx_byte), 32'd0);
    chk("reset_is_receiving", 32'(is_receiving), 32'd0);
    chk("reset_is_transmitting", 32'(is_transmitting), 32'd0);
    chk("reset_recv_error", 32'(recv_error), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_tx", 32'(tx), 32'd1);
    chk("post_reset_tx_free", 32'(tx_free), 32'd1);
    chk("post_reset_is_receiving", 32'(is_receiving), 32'd0);

    send_tx(8'hA5, 1'b0);
    wait_tx_idle();

    send_tx(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_tx_free", 32'(tx_free), 32'd0);
    transmit = 1'b1;
    tx_byte  = 8'h00;
    @(negedge clk);
    transmit = 1'b0;
    wait_tx_idle();
    repeat (12 * DIV) @(negedge clk);
    chk("busy_no_extra_frame_tx", 32'(tx), 32'd1);
    chk("busy_txq_empty", 32'(txq.size()), 32'd0);

    send_tx(8'($urandom), 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_tx_free", 32'(tx_free), 32'd1);
    chk("abort_is_transmitting", 32'(is_transmitting), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);

    push_rx(1'b1, 8'h3C);
    drive_rx_frame(8'h3C, 1'b0, DIV, 2 * DIV);
    repeat (DIV) @(negedge clk);
    push_rx(1'b0, 8'h81);
    drive_rx_frame(8'h81, 1'b1, DIV, 0);
    wait_rxq(200);

    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (DIV - 1 + SYNC_LAT) @(negedge clk);
    chk("false_start_is_receiving", 32'(is_receiving), 32'd0);
    repeat (4 * DIV) @(negedge clk);

    fork
      begin : rand_tx
        for (int i = 0; i < 16; i++) begin
          send_tx(8'($urandom), 1'b0);
          repeat ($urandom_range(0, 30)) @(negedge clk);
        end
      end
      begin : rand_rx
        logic [7:0] rb;
        bit         ok;
        for (int i = 0; i < 16; i++) begin
          rb = 8'($urandom);
          ok = ($urandom_range(0, 4) != 0);
          push_rx(!ok, rb);
          drive_rx_frame(rb, ok, DIV - int'($urandom_range(0, DIV / 2 - 1)),
                         int'($urandom_range(0, 2 * DIV)));
          repeat (ok ? $urandom_range(0, 6) : $urandom_range(1, 6)) @(negedge clk);
        end
      end
    join
    wait_tx_idle();
    wait_rxq(400);

    loop_en = 1'b1;
    for (int i = 0; i < 256; i++) send_tx(8'(i), 1'b1);
    wait_tx_idle();
    wait_rxq(DLY + 2000);

    chk("final_txq_empty", 32'(txq.size()), 32'd0);
    chk("final_tx_idle", 32'(tx), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
